jt1943_rom_arb: RTL and testbench
=================================

# jt1943_rom_arb

Arbiter sharing the single game-side SDRAM read port among four ROM requesters: main CPU, sound CPU, character layer and object layer. It sits between the game core's ROM fetch logic and the board SDRAM controller's request/ack/ready port. Each requester slot keeps a one-entry data cache, so repeated reads of the same word never reach SDRAM. The block also holds the port idle during ROM download and SDRAM loop reset, and grants refresh windows whenever no request is pending.

## Interface
Parameters:
- AW, 22, SDRAM word-address width
- DW, 32, read data width
- TOUT, 255, cycles allowed from ack to data_rdy before abort and retry

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset: synchronous, active-high
- downloading  in  1  ROM download active; port held idle
- loop_rst  in  1  SDRAM controller init loop; port held idle
- slot_req  in  4  per-slot request level; held high with stable address until slot_ok
- slot_addr  in  4×AW  per-slot word address (packed, slot 0 in LSBs)
- slot_ok  out  4  one-cycle pulse: slot_dout valid for that slot
- slot_dout  out  DW  shared read data, valid in the slot_ok cycle and held until the next slot_ok
- sdram_req  out  1  request to SDRAM controller
- sdram_addr  out  AW  address for sdram_req
- sdram_ack  in  1  controller accepted the request (1-cycle pulse)
- data_rdy  in  1  data_read valid (1-cycle pulse)
- data_read  in  DW  SDRAM read data
- refresh_en  out  1  controller may refresh now

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE: evaluate pending slots in fixed priority order, slot 0 first (main CPU), then 1, 2, 3.
  - Pending means slot_req=1 and no slot_ok has been issued for the current address.
  - Cache hit (valid flag set and slot_addr equals the cached address): pulse slot_ok from cache and stay in IDLE. At most one hit per cycle; the highest-priority pending slot wins.
  - Miss: latch the slot index and address, then go to REQ.
- REQ: sdram_req=1 with the latched sdram_addr. On sdram_ack, go to WAIT.
- WAIT: on data_rdy, write data_read into the slot cache (set valid, store the address), then go to DONE. If the timeout counter reaches TOUT, go to IDLE without pulsing ok; the slot is still pending and retries.
- DONE: pulse slot_ok[idx], drive slot_dout from the cache, return to IDLE.
- A slot whose address changes while it is latched by REQ/WAIT still receives the data for the latched address. The requester is responsible for holding its address stable.
- refresh_en=1 only in IDLE when no slot is pending or every pending slot hits its cache. Otherwise 0.
- downloading=1 or loop_rst=1:
  - force IDLE
  - sdram_req=0
  - clear all cache valid flags
  - slot_ok=0
  - refresh_en=1
  - an ack or rdy arriving in this period is ignored.
- Address compare covers the full AW bits. A wrap from 0x3FFFFF to 0 is a normal miss.

## Timing
- Reset values:
  - state IDLE
  - sdram_req=0
  - sdram_addr=0
  - slot_ok=0
  - slot_dout=0
  - refresh_en=1
  - caches invalid
  - timeout counter 0
- Cache hit: slot_ok rises 1 cycle after the slot_req/slot_addr sample.
- Miss:
  - sdram_req rises 1 cycle after the sample.
  - sdram_req drops in the cycle after sdram_ack.
  - slot_ok rises 2 cycles after data_rdy (capture, then DONE).
- If sdram_ack and data_rdy arrive in the same cycle, treat it as ack followed by immediate ready: capture the data and go to DONE.
- The timeout counter clears on entering WAIT and counts every WAIT cycle.
- All outputs are registered.
- rst, downloading or loop_rst mid-transaction abort within 1 cycle, with no slot_ok emitted.

## Structure
- Shared package jt1943_rom_pkg:
  - state enum (IDLE, REQ, WAIT, DONE)
  - slot index constants SLOT_MAIN=0, SLOT_SND=1, SLOT_CHAR=2, SLOT_OBJ=3
- Sub-module jt1943_rom_slot, instantiated 4 times. It holds cached address, data and valid flag, and outputs hit and pending.
- Top level holds the priority encoder, FSM, timeout counter and output registers.

## Test plan
- Slot 2 requests 0x000100 with an empty cache. Controller acks after 3 cycles and gives data_rdy with 0xDEADBEEF 5 cycles later. Required: slot_ok[2] pulses 2 cycles after rdy, slot_dout=0xDEADBEEF, sdram_addr=0x000100.
- Slot 2 re-requests 0x000100. Required: slot_ok[2] pulses 1 cycle later, with no sdram_req.
- Slots 0 and 3 request in the same cycle (misses). Required: slot 0 is served first; slot 3's sdram_req rises 1 cycle after slot_ok[0].
- Ack given, then no data_rdy. Required: after 255 WAIT cycles the FSM returns to IDLE, sdram_req re-asserts for the same slot, and no spurious slot_ok occurs.
- loop_rst asserted during WAIT. Required: sdram_req=0, no slot_ok, refresh_en=1, and a later request to a previously cached address is a miss.
- rst for 1 cycle during REQ. Required: all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/jt1943_rom_pkg.sv
// Shared types and constants for the 1943 ROM port arbiter.
// Slot numbering doubles as fixed priority: lower index is served first.
package jt1943_rom_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int NSLOT = 4;

    localparam logic [1:0] SLOT_MAIN = 2'd0;
    localparam logic [1:0] SLOT_SND  = 2'd1;
    localparam logic [1:0] SLOT_CHAR = 2'd2;
    localparam logic [1:0] SLOT_OBJ  = 2'd3;

endpackage

// File: rtl/jt1943_rom_slot.sv
// One requester slot: single-word cache plus the "already answered" flag
// that keeps a held request from being served twice.
module jt1943_rom_slot #(
    parameter int AW = 22,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          req_i,
    input  logic [AW-1:0] addr_i,
    input  logic          wr_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          ok_i,
    output logic          hit_o,
    output logic          pending_o,
    output logic [DW-1:0] data_o
);

    logic [AW-1:0] addr_q;
    logic [DW-1:0] data_q;
    logic          valid_q;
    logic          served_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            served_q <= 1'b0;
        end else begin
            if (flush_i) begin
                valid_q <= 1'b0;
            end else if (wr_i) begin
                valid_q <= 1'b1;
                addr_q  <= wr_addr_i;
                data_q  <= wr_data_i;
            end
            // Served sticks while the request is held; an address change re-arms it.
            if (!req_i) begin
                served_q <= 1'b0;
            end else if (ok_i) begin
                served_q <= 1'b1;
            end
        end
    end

    assign hit_o     = valid_q && (addr_q == addr_i);
    assign pending_o = req_i && !(served_q && (addr_q == addr_i));
    assign data_o    = data_q;

endmodule

// File: rtl/jt1943_rom_arb.sv
// Shares one SDRAM read port among four cached ROM requesters with fixed
// priority, an ack-to-ready timeout, and refresh windows when idle.
module jt1943_rom_arb
    import jt1943_rom_pkg::*;
#(
    parameter int AW   = 22,
    parameter int DW   = 32,
    parameter int TOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                downloading,
    input  logic                loop_rst,
    input  logic [NSLOT-1:0]    slot_req,
    input  logic [NSLOT*AW-1:0] slot_addr,
    output logic [NSLOT-1:0]    slot_ok,
    output logic [DW-1:0]       slot_dout,
    output logic                sdram_req,
    output logic [AW-1:0]       sdram_addr,
    input  logic                sdram_ack,
    input  logic                data_rdy,
    input  logic [DW-1:0]       data_read,
    output logic                refresh_en
);

    localparam int CW = $clog2(TOUT + 1);

    logic             flush;
    logic             capture;
    logic [NSLOT-1:0] hit;
    logic [NSLOT-1:0] pending;
    logic [AW-1:0]    addr_w    [NSLOT];
    logic [DW-1:0]    slot_data [NSLOT];
    logic [1:0]       sel_idx;
    logic             sel_vld;

    state_e           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sdram_req_q, sdram_req_d;
    logic [AW-1:0]    sdram_addr_q, sdram_addr_d;
    logic [NSLOT-1:0] slot_ok_q, slot_ok_d;
    logic [DW-1:0]    slot_dout_q, slot_dout_d;
    logic             refresh_q, refresh_d;

    assign flush = downloading | loop_rst;

    generate
        for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
            assign addr_w[gi] = slot_addr[gi*AW +: AW];

            jt1943_rom_slot #(
                .AW (AW),
                .DW (DW)
            ) u_slot (
                .clk       (clk),
                .rst       (rst),
                .flush_i   (flush),
                .req_i     (slot_req[gi]),
                .addr_i    (addr_w[gi]),
                .wr_i      (capture && (idx_q == 2'(gi))),
                .wr_addr_i (sdram_addr_q),
                .wr_data_i (data_read),
                .ok_i      (slot_ok_d[gi]),
                .hit_o     (hit[gi]),
                .pending_o (pending[gi]),
                .data_o    (slot_data[gi])
            );
        end
    endgenerate

    always_comb begin
        sel_vld = 1'b0;
        sel_idx = 2'd0;
        for (int i = NSLOT - 1; i >= 0; i--) begin
            if (pending[i]) begin
                sel_vld = 1'b1;
                sel_idx = 2'(i);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        sdram_req_d  = 1'b0;
        sdram_addr_d = sdram_addr_q;
        slot_ok_d    = '0;
        slot_dout_d  = slot_dout_q;
        refresh_d    = 1'b0;
        capture      = 1'b0;
        if (flush) begin
            state_d   = IDLE;
            refresh_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    refresh_d = ~|(pending & ~hit);
                    if (sel_vld) begin
                        if (hit[sel_idx]) begin
                            slot_ok_d[sel_idx] = 1'b1;
                            slot_dout_d        = slot_data[sel_idx];
                        end else begin
                            state_d      = REQ;
                            idx_d        = sel_idx;
                            sdram_addr_d = addr_w[sel_idx];
                            sdram_req_d  = 1'b1;
                        end
                    end
                end
                REQ: begin
                    sdram_req_d = 1'b1;
                    if (sdram_ack) begin
                        sdram_req_d = 1'b0;
                        cnt_d       = '0;
                        if (data_rdy) begin
                            capture = 1'b1;
                            state_d = DONE;
                        end else begin
                            state_d = WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt_d = cnt_q + CW'(1);
                    if (data_rdy) begin
                        capture = 1'b1;
                        state_d = DONE;
                    end else if (cnt_q == CW'(TOUT - 1)) begin
                        // Give up silently; the slot is still pending and retries.
                        state_d = IDLE;
                    end
                end
                DONE: begin
                    slot_ok_d   = NSLOT'(1) << idx_q;
                    slot_dout_d = slot_data[idx_q];
                    state_d     = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= 2'd0;
            cnt_q        <= '0;
            sdram_req_q  <= 1'b0;
            sdram_addr_q <= '0;
            slot_ok_q    <= '0;
            slot_dout_q  <= '0;
            refresh_q    <= 1'b1;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            sdram_req_q  <= sdram_req_d;
            sdram_addr_q <= sdram_addr_d;
            slot_ok_q    <= slot_ok_d;
            slot_dout_q  <= slot_dout_d;
            refresh_q    <= refresh_d;
        end
    end

    assign sdram_req  = sdram_req_q;
    assign sdram_addr = sdram_addr_q;
    assign slot_ok    = slot_ok_q;
    assign slot_dout  = slot_dout_q;
    assign refresh_en = refresh_q;

endmodule

// File: tb/tb_jt1943_rom_arb.sv
// Bench for jt1943_rom_arb: a latency-programmable SDRAM responder plus a
// transaction-level model of per-slot caches, service order and timing.
module tb_jt1943_rom_arb;

    localparam int AW   = 22;
    localparam int DW   = 32;
    localparam int TOUT = 255;

    logic          clk = 1'b0;
    logic          rst;
    logic          downloading;
    logic          loop_rst;
    logic [3:0]    slot_req;
    logic [4*AW-1:0] slot_addr;
    logic [3:0]    slot_ok;
    logic [DW-1:0] slot_dout;
    logic          sdram_req;
    logic [AW-1:0] sdram_addr;
    logic          sdram_ack;
    logic          data_rdy;
    logic [DW-1:0] data_read;
    logic          refresh_en;

    int n_checks = 0;
    int n_errors = 0;

    int ack_dly   = 0;
    int rdy_dly   = 0;
    bit drop_once = 1'b0;

    logic          mv [4];
    logic [AW-1:0] ma [4];
    logic [AW-1:0] raddr [4];

    jt1943_rom_arb #(.AW(AW), .DW(DW), .TOUT(TOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .downloading (downloading),
        .loop_rst    (loop_rst),
        .slot_req    (slot_req),
        .slot_addr   (slot_addr),
        .slot_ok     (slot_ok),
        .slot_dout   (slot_dout),
        .sdram_req   (sdram_req),
        .sdram_addr  (sdram_addr),
        .sdram_ack   (sdram_ack),
        .data_rdy    (data_rdy),
        .data_read   (data_read),
        .refresh_en  (refresh_en)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        if (a == 22'h000100) return 32'hDEADBEEF;
        return {a[9:0], a} ^ 32'hA5C3_0F1E;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic invalidate_model();
        for (int s = 0; s < 4; s++) mv[s] = 1'b0;
    endtask

    task automatic drive_addrs();
        for (int s = 0; s < 4; s++) slot_addr[s*AW +: AW] = raddr[s];
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sdram_req"},  sdram_req,  0);
        check({tag, "_sdram_addr"}, sdram_addr, 0);
        check({tag, "_slot_ok"},    slot_ok,    0);
        check({tag, "_slot_dout"},  slot_dout,  0);
        check({tag, "_refresh"},    refresh_en, 1);
    endtask

    // SDRAM controller: ack after ack_dly cycles of sdram_req, data rdy_dly later.
    initial begin
        int acnt;
        int rcnt;
        int ph;
        logic [AW-1:0] lat;
        acnt = 0; rcnt = 0; ph = 0; lat = '0;
        sdram_ack = 1'b0;
        data_rdy  = 1'b0;
        data_read = '0;
        forever begin
            tick();
            sdram_ack = 1'b0;
            data_rdy  = 1'b0;
            if (ph == 0) begin
                if (sdram_req) begin
                    if (acnt == ack_dly) begin
                        sdram_ack = 1'b1;
                        lat  = sdram_addr;
                        acnt = 0;
                        if (drop_once) begin
                            drop_once = 1'b0;
                        end else if (rdy_dly == 0) begin
                            data_rdy  = 1'b1;
                            data_read = mem_word(lat);
                        end else begin
                            ph   = 1;
                            rcnt = 0;
                        end
                    end else begin
                        acnt++;
                    end
                end else begin
                    acnt = 0;
                end
            end else begin
                rcnt++;
                if (rcnt == rdy_dly) begin
                    data_rdy  = 1'b1;
                    data_read = mem_word(lat);
                    ph = 0;
                end
            end
        end
    end

    // Raise every slot in mask at once and follow the service sequence:
    // ascending slot order, one service step per cycle after each ok,
    // misses answered ack_dly+rdy_dly+2 cycles after their sdram_req rise.
    task automatic run_batch(input logic [3:0] mask, input bit retry);
        logic [3:0] outst;
        logic [3:0] one;
        int k, ref_k, rise_k, e, rises, exp_rises;
        bit rise_seen, await_retry, do_retry, miss_e;
        logic prev_req;
        outst = mask; one = 4'b0001;
        k = 0; ref_k = 0; rise_k = 0; rises = 0; exp_rises = 0;
        rise_seen = 1'b0; await_retry = 1'b0; do_retry = retry;
        drive_addrs();
        slot_req = mask;
        prev_req = sdram_req;
        while (outst != 4'b0 && k < 600) begin
            tick();
            k++;
            e = 0;
            for (int s = 3; s >= 0; s--) if (outst[s]) e = s;
            miss_e = !(mv[e] && ma[e] == raddr[e]);
            if (sdram_req && !prev_req) begin
                rises++;
                if (await_retry) begin
                    check("retry_gap", k - rise_k, ack_dly + TOUT + 2);
                    await_retry = 1'b0;
                end else begin
                    check("req_is_miss", 1'b1, miss_e);
                    check("req_gap", k - ref_k, 1);
                    if (do_retry) begin
                        await_retry = 1'b1;
                        do_retry    = 1'b0;
                    end
                end
                check("req_addr", sdram_addr, raddr[e]);
                check("refresh_in_req", refresh_en, 0);
                rise_k = k;
                rise_seen = 1'b1;
            end
            prev_req = sdram_req;
            if (slot_ok != 4'b0) begin
                check("ok_slot", slot_ok, one << e);
                check("ok_data", slot_dout, mem_word(raddr[e]));
                if (miss_e) begin
                    check("ok_after_req", rise_seen, 1);
                    check("ok_gap", k - rise_k, ack_dly + rdy_dly + 2);
                    exp_rises++;
                end else begin
                    check("hit_gap", k - ref_k, 1);
                end
                mv[e] = 1'b1;
                ma[e] = raddr[e];
                outst[e] = 1'b0;
                slot_req[e] = 1'b0;
                ref_k = k;
                rise_seen = 1'b0;
            end
        end
        check("batch_done", outst, 0);
        check("sdram_req_count", rises, exp_rises + (retry ? 1 : 0));
        $display("batch mask=%b retry=%0d ack_dly=%0d rdy_dly=%0d cycles=%0d sdram_reqs=%0d",
                 mask, retry, ack_dly, rdy_dly, k, rises);
        slot_req = 4'b0;
        tick();
        check("idle_refresh", refresh_en, 1);
        check("idle_sdram_req", sdram_req, 0);
    endtask

    initial begin
        int k;
        logic [3:0] mask;
        rst = 1'b1; downloading = 1'b0; loop_rst = 1'b0;
        slot_req = 4'b0; slot_addr = '0;
        for (int s = 0; s < 4; s++) raddr[s] = '0;
        invalidate_model();
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Cold miss on the character slot, then a cache hit on the same word
        ack_dly = 3; rdy_dly = 5;
        raddr[2] = 22'h000100;
        run_batch(4'b0100, 1'b0);
        check("t1_dout", slot_dout, 32'hDEADBEEF);
        check("t1_addr", sdram_addr, 22'h000100);
        run_batch(4'b0100, 1'b0);

        // Simultaneous misses on main CPU and object slots
        ack_dly = 1; rdy_dly = 2;
        raddr[0] = 22'h000200; raddr[3] = 22'h000300;
        run_batch(4'b1001, 1'b0);

        // Ack without data: timeout and retry of the same slot
        drop_once = 1'b1; ack_dly = 2; rdy_dly = 3;
        raddr[1] = 22'h001234;
        run_batch(4'b0010, 1'b1);

        // Address wrap is an ordinary miss
        ack_dly = 0; rdy_dly = 0;
        raddr[0] = 22'h3FFFFF;
        run_batch(4'b0001, 1'b0);
        raddr[0] = 22'h000000;
        run_batch(4'b0001, 1'b0);

        // loop_rst while waiting for data
        ack_dly = 1; rdy_dly = 6;
        raddr[2] = 22'h000555;
        drive_addrs();
        slot_req = 4'b0100;
        k = 0;
        while (!sdram_req && k < 20) begin tick(); k++; end
        check("t5_req_seen", sdram_req, 1);
        tick(); tick();
        loop_rst = 1'b1;
        slot_req = 4'b0;
        tick();
        check("t5_sdram_req", sdram_req, 0);
        check("t5_slot_ok", slot_ok, 0);
        check("t5_refresh", refresh_en, 1);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t5_hold_ok", slot_ok, 0);
            check("t5_hold_req", sdram_req, 0);
        end
        loop_rst = 1'b0;
        tick();
        invalidate_model();
        run_batch(4'b1000, 1'b0);

        // Synchronous reset while the request is outstanding
        ack_dly = 4;
        raddr[1] = 22'h000777;
        drive_addrs();
        slot_req = 4'b0010;
        k = 0;
        while (!sdram_req && k < 20) begin tick(); k++; end
        check("t6_req_seen", sdram_req, 1);
        rst = 1'b1;
        slot_req = 4'b0;
        tick();
        check_reset_outputs("t6");
        rst = 1'b0;
        tick();
        invalidate_model();

        // Randomized batches with occasional download flushes
        for (int b = 0; b < 30; b++) begin
            if ($urandom_range(0, 5) == 0) begin
                downloading = 1'b1;
                tick(); tick();
                check("dl_refresh", refresh_en, 1);
                check("dl_no_req", sdram_req, 0);
                downloading = 1'b0;
                tick();
                invalidate_model();
            end
            ack_dly = $urandom_range(0, 3);
            rdy_dly = $urandom_range(0, 4);
            for (int s = 0; s < 4; s++) begin
                case ($urandom_range(0, 3))
                    0: raddr[s] = 22'h000000;
                    1: raddr[s] = 22'h3FFFFF;
                    2: raddr[s] = 22'h000100;
                    default: raddr[s] = 22'(s * 64 + 1);
                endcase
            end
            mask = 4'($urandom_range(1, 15));
            run_batch(mask, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
